// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] MEM_MODE_WORD = 2'b00;
  localparam logic [1:0] MEM_MODE_BYTE = 2'b01;
  localparam logic [1:0] MEM_MODE_HALF = 2'b10;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISAL   = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  // access size comes from funct3[1:0]; the unsigned bit does not matter to the controller
  function automatic logic [1:0] mode_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? MEM_MODE_BYTE : f3[1:0] == 2'b01 ? MEM_MODE_HALF : MEM_MODE_WORD;
  endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero extension of controller read data by load funct3
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);
  // controller already zero-extends byte/half reads, so only the sign fill is added here
  always_comb begin
    result = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]}
           : funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]}
           : funct3 == F3_BU ? {24'b0, raw[7:0]}
           : funct3 == F3_HU ? {16'b0, raw[15:0]}
           : raw;
  end
endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: single-outstanding RV32 load/store unit in front of the memory controller
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [11:0]       req_imm,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_enable,
  output logic [31:0]       mem_data_in,
  output logic [1:0]        mem_mode,
  input  logic [31:0]       mem_data_out,
  input  logic              mem_op_r
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t            state, state_n;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, ea, ext;
  logic [CW-1:0]     cnt;
  logic              illegal, misal, range_f, timeout, act;
  logic [1:0]        err_in;

  lsu_load_extend u_ext (.funct3(f3_q), .raw(mem_data_out), .result(ext));

  // address generation and request checks, priority illegal > misaligned > range
  always_comb begin
    ea      = req_base + {{20{req_imm[11]}}, req_imm};
    illegal = (req_store && req_funct3[2]) || req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11;
    misal   = (req_funct3[1:0] == 2'b01 && ea[0]) || (req_funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
    range_f = |ea[31:ADDR_W];
    err_in  = illegal ? ERR_RANGE : misal ? ERR_MISAL : range_f ? ERR_RANGE : ERR_OK;
    timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  end

  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;

  // next state and handshake/controller outputs; controller signals stay put through WAIT
  always_comb begin
    state_n     = state == IDLE  ? (req_valid ? (err_in != ERR_OK ? RESP : ISSUE) : IDLE)
                : state == ISSUE ? WAIT
                : state == WAIT  ? ((mem_op_r || timeout) ? RESP : WAIT)
                : (resp_ready ? IDLE : RESP);
    act         = state == ISSUE || state == WAIT;
    req_ready   = state == IDLE;
    resp_valid  = state == RESP;
    mem_enable  = state == ISSUE;
    mem_we      = act && store_q;
    mem_addr    = act ? addr_q : '0;
    mem_mode    = act ? mode_of(f3_q) : MEM_MODE_WORD;
    mem_data_in = act ? wdata_q : '0;
  end

  // request latch, wait counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q   <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_err  <= ERR_OK;
    end else begin
      if (state == IDLE && req_valid) begin
        store_q   <= req_store;
        f3_q      <= req_funct3;
        addr_q    <= ea[ADDR_W-1:0];
        wdata_q   <= req_wdata;
        resp_data <= '0;
        resp_err  <= err_in;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (mem_op_r || timeout) begin
          resp_data <= (mem_op_r && !store_q) ? ext : '0;
          resp_err  <= mem_op_r ? ERR_OK : ERR_TIMEOUT;
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed scoreboard bench for lsu_unit with a 4-cycle controller stub
module tb_lsu_unit;
  logic        clk, rst, req_valid, req_ready, req_store, resp_valid, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_wdata, resp_data, mem_data_in, mem_data_out;
  logic [11:0] req_imm;
  logic [1:0]  resp_err, mem_mode;
  logic [23:0] mem_addr;
  logic        mem_we, mem_enable, mem_op_r;
  logic        mute, load_init;
  logic [7:0]  mem [0:255];
  logic [2:0]  k;
  logic [7:0]  a;
  logic [33:0] exp_q [$];
  int          errors = 0, checks = 0;
  localparam logic [31:0] INIT = 32'h0020e863;

  lsu_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_imm(req_imm), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_enable(mem_enable),
    .mem_data_in(mem_data_in), .mem_mode(mem_mode), .mem_data_out(mem_data_out),
    .mem_op_r(mem_op_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a = mem_addr[7:0];

  // controller stub: op_r four edges after the enable edge, no reset of its own
  always @(posedge clk) begin
    mem_op_r <= 1'b0;
    if (load_init) begin
      k <= 3'd0;
      mem_data_out <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= (i < 4) ? INIT[8*i +: 8] : 8'h00;
    end else if (mem_enable) begin
      k <= 3'd1;
    end else if (k != 3'd0) begin
      k <= (k == 3'd4) ? 3'd0 : k + 3'd1;
      if (k == 3'd4 && !mute) begin
        mem_op_r <= 1'b1;
        mem_data_out <= mem_mode == 2'b01 ? {24'b0, mem[a]}
                      : mem_mode == 2'b10 ? {16'b0, mem[a + 8'd1], mem[a]}
                      : {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
        if (mem_we) begin
          mem[a] <= mem_data_in[7:0];
          if (mem_mode != 2'b01) mem[a + 8'd1] <= mem_data_in[15:8];
          if (mem_mode == 2'b00) begin
            mem[a + 8'd2] <= mem_data_in[23:16];
            mem[a + 8'd3] <= mem_data_in[31:24];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] base,
                     input logic [11:0] imm, input logic [31:0] wd, input logic [31:0] exp_d,
                     input logic [1:0] exp_e, input int exp_lat, input int hold);
    int lat, en_n, en_at;
    logic we_s;
    logic [23:0] a_s;
    logic [31:0] ea;
    logic [33:0] e;
    ea = base + {{20{imm[11]}}, imm};
    en_n = 0; en_at = 0; we_s = 1'b0; a_s = '0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_base = base; req_imm = imm; req_wdata = wd;
    exp_q.push_back({exp_e, exp_d});
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_enable) begin en_n++; en_at = lat; we_s = mem_we; a_s = mem_addr; end
      if (resp_valid) break;
    end
    chk({tag, " latency"}, lat, exp_lat);
    e = exp_q.pop_front();
    if (!resp_valid) return;
    chk({tag, " data"}, resp_data, e[31:0]);
    chk({tag, " err"}, {30'b0, resp_err}, {30'b0, e[33:32]});
    if (exp_e == 2'b00 || exp_e == 2'b11) begin
      chk({tag, " enable count"}, en_n, 1);
      chk({tag, " enable cycle"}, en_at, 1);
      chk({tag, " we"}, {31'b0, we_s}, {31'b0, st});
      chk({tag, " addr"}, {8'b0, a_s}, {8'b0, ea[23:0]});
    end else begin
      chk({tag, " no enable"}, en_n, 0);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid/ready"}, {30'b0, resp_valid, req_ready}, 32'd2);
      chk({tag, " hold data"}, resp_data, e[31:0]);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " back to idle"}, {30'b0, req_ready, resp_valid}, 32'd2);
  endtask

  initial begin
    rst = 1'b1; load_init = 1'b1; mute = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_base = '0; req_imm = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready/valid/enable/we", {28'b0, req_ready, resp_valid, mem_enable, mem_we}, 32'h8);
    chk("reset data", resp_data, 32'h0);
    chk("reset err/mode", {28'b0, resp_err, mem_mode}, 32'h0);
    chk("reset addr", {8'b0, mem_addr}, 32'h0);
    chk("reset data_in", mem_data_in, 32'h0);
    rst = 1'b0; load_init = 1'b0;

    run("lw 0",      1'b0, 3'b010, 32'h0,        12'h000, 32'h0,        32'h0020e863, 2'b00, 7, 0);
    run("lb 1",      1'b0, 3'b000, 32'h0,        12'h001, 32'h0,        32'hffffffe8, 2'b00, 7, 0);
    run("lbu 1",     1'b0, 3'b100, 32'h0,        12'h001, 32'h0,        32'h000000e8, 2'b00, 7, 0);
    run("lh 4-4",    1'b0, 3'b001, 32'h4,        12'hffc, 32'h0,        32'hffffe863, 2'b00, 7, 0);
    run("sh 10",     1'b1, 3'b001, 32'h10,       12'h000, 32'h1234abcd, 32'h0,        2'b00, 7, 0);
    run("lhu 10",    1'b0, 3'b101, 32'h10,       12'h000, 32'h0,        32'h0000abcd, 2'b00, 7, 0);
    run("sw misal",  1'b1, 3'b010, 32'h2,        12'h000, 32'hdeadbeef, 32'h0,        2'b01, 1, 0);
    run("lw range",  1'b0, 3'b010, 32'h01000000, 12'h000, 32'h0,        32'h0,        2'b10, 1, 0);
    run("st f3 100", 1'b1, 3'b100, 32'h0,        12'h000, 32'h0,        32'h0,        2'b10, 1, 0);
    run("ld f3 011", 1'b0, 3'b011, 32'h01000001, 12'h000, 32'h0,        32'h0,        2'b10, 1, 0);
    run("misal>rng", 1'b0, 3'b010, 32'h01000002, 12'h000, 32'h0,        32'h0,        2'b01, 1, 0);
    run("lw wrap",   1'b0, 3'b010, 32'h01000004, 12'hff8, 32'h0,        32'h0,        2'b00, 7, 0);

    mute = 1'b1;
    run("timeout",   1'b0, 3'b010, 32'h0,        12'h000, 32'h0,        32'h0,        2'b11, 18, 0);
    mute = 1'b0;

    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h0; req_imm = 12'h000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("abort idle valid/ready/enable", {29'b0, resp_valid, req_ready, mem_enable}, 32'd2);
      @(negedge clk);
    end
    run("lw after rst", 1'b0, 3'b010, 32'h0, 12'h000, 32'h0, 32'h0020e863, 2'b00, 7, 0);
    run("lw hold",      1'b0, 3'b010, 32'h0, 12'h000, 32'h0, 32'h0020e863, 2'b00, 7, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit between the core's execute stage and memory_controller_module.
- Accepts one RV32 load/store request at a time and computes the effective address (base + sign-extended imm12).
- Checks alignment and range, drives the controller's enable/addr/we/mode/data_in, and waits for op_r.
- Sign- or zero-extends the returned data, then returns a response with an error code to the core.

Parameters:
- ADDR_W, 24, width of the memory address bus to the controller.
- TIMEOUT_CYCLES, 16, number of WAIT cycles without mem_op_r before a timeout error is returned.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request (high in IDLE only).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 (loads 000/001/010/100/101; stores 000/001/010).
- req_base  in  32  rs1 value.
- req_imm  in  12  signed immediate.
- req_wdata  in  32  rs2 value (stores).
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  core accepts the response.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 out-of-range/illegal funct3, 11 timeout.
- mem_addr  out  ADDR_W  controller address.
- mem_we  out  1  controller write enable.
- mem_enable  out  1  one-cycle start pulse.
- mem_data_in  out  32  store data.
- mem_mode  out  2  00 word, 01 byte, 10 half.
- mem_data_out  in  32  controller read data; zero-extended for byte/half.
- mem_op_r  in  1  controller data-ready strobe.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0 except req_ready=1; timeout counter=0.
- Reset mid-transaction aborts to IDLE. The controller has no reset and may still finish its access; mem_op_r is ignored outside WAIT.
- Effective address: ea = req_base + sext(req_imm), 32-bit with wrap-around.
- Misaligned: half access with ea[0]≠0, or word access with ea[1:0]≠0.
- Range fault: ea[31:ADDR_W]≠0. Stores with funct3[2]=1, and funct3 011/110/111, are illegal.
- Error priority: illegal > misaligned > range.
- State machine:
  - IDLE: req_ready=1. On req_valid, latch request. If an error is detected, go to RESP with that error code; otherwise go to ISSUE.
  - ISSUE: mem_enable=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: mem_addr, mem_we, mem_mode and mem_data_in are held stable, because the controller samples we, mode and data at its internal count 3.
    - mem_op_r=1: capture extended data; err=00; go to RESP.
    - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without op_r: err=11; go to RESP.
    - If op_r and timeout coincide, op_r wins.
  - RESP: resp_valid=1, data and err held stable. When resp_ready=1, go to IDLE; req_ready rises the next cycle, so there is no same-cycle re-accept.
- mem_enable is 0 in every state except ISSUE; mem_we=req_store during ISSUE and WAIT.
- Extension, by latched funct3 on mem_data_out:
  - lb: sign-extend bit 7.
  - lh: sign-extend bit 15.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- Latency (N = accept cycle, with the current 4-cycle controller):
  - ISSUE in N+1; mem_op_r in N+6; resp_valid from N+7.
  - Error responses from N+1.

Decomposition:
- lsu_pkg: funct3 constants, MEM_MODE_{WORD,BYTE,HALF}, ERR_{OK,MISAL,RANGE,TIMEOUT}, state encoding {IDLE,ISSUE,WAIT,RESP}.
- Sub-module lsu_load_extend: combinational extender (funct3, raw data -> 32-bit result).

Test Plan:
- Memory bytes 0x00..0x03 = 63 e8 20 00:
  - lw, base=0, imm=0 -> resp_data=0x0020e863, err=00, resp_valid at N+7, mem_enable high only in N+1.
  - lb, base=0, imm=1 -> 0xffffffe8; lbu, same address -> 0x000000e8.
  - lh, base=4, imm=-4 -> 0xffffe863.
- sh, base=0x10, wdata=0x1234abcd, then lhu at 0x10 -> store response data=0, err=00; load returns 0x0000abcd.
- sw at ea=0x2 -> err=01 at N+1, mem_enable never asserts; lw at ea=0x01000000 -> err=10; store with funct3=100 -> err=10.
- Stub controller holding mem_op_r=0 -> err=11 after 16 WAIT cycles, then back to IDLE.
- rst pulsed during WAIT, with a late mem_op_r arriving afterwards -> IDLE, resp_valid stays 0, req_ready=1; the next lw completes normally.
- resp_ready held low 5 cycles in RESP -> resp_valid/resp_data stable, req_ready=0 throughout.
